// File: rtl/stp_fsm_pkg.sv
// Shared definitions for the polynomial store (STP) and evaluate (EVP) FSMs:
// state encodings, degree limit, status codes and a ceiling-log2 helper.
package stp_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CHECK_N,
        ST_RD_COEF,
        ST_WR_COEF,
        ST_WR_N,
        ST_ERROR,
        ST_END
    } stp_state_e;

    localparam logic [4:0]  MAX_N          = 5'd10;
    localparam logic [31:0] STATUS_OK      = 32'd0;
    localparam logic [31:0] STATUS_BAD_N   = 32'd1;
    localparam logic [31:0] STATUS_IDLE    = 32'hFFFF_FFFF;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/stp_fsm.sv
// Polynomial store FSM: copies N+1 coefficients from the data-token buffer
// into slot A of the S RAM, then records the degree N in the N RAM.
module stp_fsm
    import stp_fsm_pkg::*;
#(
    parameter int  buffer_size = 1024,
    localparam int AW          = log2_ceil(buffer_size)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stp,
    input  logic [2:0]    A,
    input  logic [4:0]    N,
    input  logic [AW-1:0] rd_addr_data,
    input  logic [15:0]   ram_out_data,
    output logic          en_rd_data,
    output logic [AW-1:0] rd_addr_data_updated,
    output logic          en_wr_S,
    output logic [2:0]    wr_addr_S_vec,
    output logic [3:0]    wr_addr_S_coef,
    output logic [15:0]   wr_data_S,
    output logic          en_wr_N,
    output logic [2:0]    wr_addr_N,
    output logic [4:0]    wr_data_N,
    output logic          done_stp,
    output logic [31:0]   status
);

    stp_state_e    state_q, state_d;
    logic [2:0]    a_q, a_d;
    logic [4:0]    n_q, n_d;
    logic [3:0]    k_q, k_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   status_q, status_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            ptr_q    <= '0;
            status_q <= STATUS_IDLE;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            n_q      <= n_d;
            k_q      <= k_d;
            ptr_q    <= ptr_d;
            status_q <= status_d;
        end
    end

    // Enables and write ports are decoded from the state register; addresses
    // and data are forced to zero outside their own state.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        n_d            = n_q;
        k_d            = k_q;
        ptr_d          = ptr_q;
        status_d       = status_q;
        en_rd_data     = 1'b0;
        en_wr_S        = 1'b0;
        wr_addr_S_vec  = '0;
        wr_addr_S_coef = '0;
        wr_data_S      = '0;
        en_wr_N        = 1'b0;
        wr_addr_N      = '0;
        wr_data_N      = '0;
        done_stp       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_stp) begin
                    state_d  = ST_START;
                    a_d      = A;
                    n_d      = N;
                    ptr_d    = rd_addr_data;
                    status_d = STATUS_IDLE;
                end
            end
            ST_START: state_d = ST_CHECK_N;
            ST_CHECK_N: begin
                if (n_q > MAX_N) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_RD_COEF;
                    k_d     = '0;
                end
            end
            ST_RD_COEF: begin
                en_rd_data = 1'b1;
                state_d    = ST_WR_COEF;
            end
            ST_WR_COEF: begin
                // Read data from the previous RD_COEF cycle is valid here.
                en_wr_S        = 1'b1;
                wr_addr_S_vec  = a_q;
                wr_addr_S_coef = k_q;
                wr_data_S      = ram_out_data;
                ptr_d          = (ptr_q == AW'(buffer_size - 1)) ? '0 : ptr_q + 1'b1;
                k_d            = k_q + 4'd1;
                state_d        = ({1'b0, k_q} == n_q) ? ST_WR_N : ST_RD_COEF;
            end
            ST_WR_N: begin
                en_wr_N   = 1'b1;
                wr_addr_N = a_q;
                wr_data_N = n_q;
                status_d  = STATUS_OK;
                state_d   = ST_END;
            end
            ST_ERROR: begin
                status_d = STATUS_BAD_N;
                state_d  = ST_END;
            end
            ST_END: begin
                done_stp = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_addr_data_updated = ptr_q;
    assign status               = status_q;

endmodule
